// File: rtl/timer_pkg.sv
// Shared types and helpers for the countdown timer core.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam int SEC_MAX = 59;

    // Split a binary value 0..99 into {tens, ones} BCD digits.
    function automatic logic [7:0] bin2bcd8(input logic [6:0] value);
        return {4'(value / 7'd10), 4'(value % 7'd10)};
    endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: one-cycle pulse when the registered previous level is 0 and the input is 1.
module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev;

    // History resets to 1 so a level held high through reset is not seen as a new edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev <= 1'b1;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV enabled cycles; holds its count while disabled.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    assign tick = en && (count == CW'(DIV - 1));

    // Divider count: clear has priority, otherwise advance only while enabled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (tick) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer core: start/pause/stop, +ADD_SEC quick add, timed alarm and blink flag, BCD display outputs.
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV    = 100_000_000,
    parameter int MAX_MIN     = 99,
    parameter int ADD_SEC     = 30,
    parameter int DONE_HOLD_S = 3,
    parameter int BLINK_DIV   = TICK_DIV / 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       add,
    input  logic [6:0] min_in,
    input  logic [6:0] sec_in,
    output logic       running,
    output logic       paused,
    output logic       done,
    output logic       blink,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd
);

    localparam int MIN_W   = (MAX_MIN > 1) ? $clog2(MAX_MIN + 1) : 1;
    localparam int HOLD_W  = (DONE_HOLD_S > 1) ? $clog2(DONE_HOLD_S) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [MIN_W-1:0] MIN_LIMIT = MIN_W'(MAX_MIN);
    localparam logic [5:0]       SEC_LIMIT = 6'(SEC_MAX);

    state_t             state, state_n;
    logic [MIN_W-1:0]   min_cnt, min_n;
    logic [5:0]         sec_cnt, sec_n;
    logic [HOLD_W-1:0]  hold_cnt, hold_n;
    logic [BLINK_W-1:0] blink_cnt;

    logic start_ev, stop_ev, pause_ev, add_ev;
    logic tick, tick_en, tick_clr;

    logic [6:0]       load_min7;
    logic [MIN_W-1:0] load_min;
    logic [5:0]       load_sec;
    logic             load_nz;

    logic [6:0]       sum_sec;
    logic [MIN_W-1:0] add_min;
    logic [5:0]       add_sec;

    logic [6:0] disp_min, disp_sec;

    edge_detector u_start_edge (.clock(clock), .reset(reset), .level(start), .rise(start_ev));
    edge_detector u_stop_edge  (.clock(clock), .reset(reset), .level(stop),  .rise(stop_ev));
    edge_detector u_pause_edge (.clock(clock), .reset(reset), .level(pause), .rise(pause_ev));
    edge_detector u_add_edge   (.clock(clock), .reset(reset), .level(add),   .rise(add_ev));

    assign tick_en = (state == RUN) || (state == ALARM);

    tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clock(clock),
        .reset(reset),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick)
    );

    assign load_min7 = (min_in > 7'(MAX_MIN)) ? 7'(MAX_MIN) : min_in;
    assign load_min  = MIN_W'(load_min7);
    assign load_sec  = (sec_in > 7'(SEC_MAX)) ? SEC_LIMIT : sec_in[5:0];
    assign load_nz   = (load_min7 != 7'd0) || (load_sec != 6'd0);

    // Counter value after adding ADD_SEC, carrying into minutes and saturating at MAX_MIN:59.
    always_comb begin
        sum_sec = 7'(sec_cnt) + 7'(ADD_SEC);
        add_min = min_cnt;
        add_sec = 6'(sum_sec);
        if (sum_sec > 7'(SEC_MAX)) begin
            if (min_cnt >= MIN_LIMIT) begin
                add_min = MIN_LIMIT;
                add_sec = SEC_LIMIT;
            end else begin
                add_min = min_cnt + MIN_W'(1);
                add_sec = 6'(sum_sec - 7'd60);
            end
        end
    end

    // Next state and counters; events resolve as stop > pause > start > add, and an acting event swallows that cycle's tick.
    always_comb begin
        state_n  = state;
        min_n    = min_cnt;
        sec_n    = sec_cnt;
        hold_n   = hold_cnt;
        tick_clr = 1'b0;
        case (state)
            IDLE: begin
                if (start_ev && load_nz) begin
                    state_n  = RUN;
                    min_n    = load_min;
                    sec_n    = load_sec;
                    tick_clr = 1'b1;
                end else if (add_ev) begin
                    state_n  = RUN;
                    min_n    = '0;
                    sec_n    = 6'(ADD_SEC);
                    tick_clr = 1'b1;
                end
            end
            RUN: begin
                if (stop_ev) begin
                    state_n = IDLE;
                    min_n   = '0;
                    sec_n   = '0;
                end else if (pause_ev) begin
                    state_n = PAUSE;
                end else if (add_ev) begin
                    min_n = add_min;
                    sec_n = add_sec;
                end else if (tick) begin
                    if (sec_cnt != 6'd0) begin
                        sec_n = sec_cnt - 6'd1;
                    end else begin
                        min_n = min_cnt - MIN_W'(1);
                        sec_n = SEC_LIMIT;
                    end
                    if (min_cnt == '0 && sec_cnt == 6'd1) begin
                        state_n = ALARM;
                        hold_n  = '0;
                    end
                end
            end
            PAUSE: begin
                if (stop_ev) begin
                    state_n = IDLE;
                    min_n   = '0;
                    sec_n   = '0;
                end else if (pause_ev || start_ev) begin
                    state_n = RUN;
                end else if (add_ev) begin
                    min_n = add_min;
                    sec_n = add_sec;
                end
            end
            ALARM: begin
                if (stop_ev || start_ev) begin
                    state_n = IDLE;
                    hold_n  = '0;
                end else if (tick) begin
                    if (hold_cnt == HOLD_W'(DONE_HOLD_S - 1)) begin
                        state_n = IDLE;
                        hold_n  = '0;
                    end else begin
                        hold_n = hold_cnt + HOLD_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, time counters and alarm hold counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            min_cnt  <= '0;
            sec_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            min_cnt  <= min_n;
            sec_cnt  <= sec_n;
            hold_cnt <= hold_n;
        end
    end

    // Registered status flags, aligned with the state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            paused  <= 1'b0;
            done    <= 1'b0;
        end else begin
            running <= (state_n == RUN);
            paused  <= (state_n == PAUSE);
            done    <= (state_n == ALARM);
        end
    end

    // Blink half-period counter: restarts on entering PAUSE/ALARM, forced off in IDLE/RUN.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (state_n == IDLE || state_n == RUN || state_n != state) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    assign disp_min = (state == IDLE) ? load_min7 : 7'(min_cnt);
    assign disp_sec = (state == IDLE) ? 7'(load_sec) : 7'(sec_cnt);
    assign min_bcd  = bin2bcd8(disp_min);
    assign sec_bcd  = bin2bcd8(disp_sec);

endmodule
